// File: rtl/uart_xcvr.sv
// UART transceiver: shared 16x oversample tick, TX and RX FSMs, a single-entry RX holding register
// with parity/framing/overrun flags, and an optional echo of good received frames back out on txd.
module uart_xcvr #(
   parameter int DIV       = 2604,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 CLK,
   input  logic                 rst_p,
   input  logic                 rxd,
   output logic                 txd,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_overrun,
   input  logic                 echo_en,
   output logic                 tick_16x
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_ONE   = CW'(1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_EN    = (PARITY != 0);
   localparam logic          PAR_ODD   = (PARITY == 1);

   localparam logic [2:0] TX_IDLE  = 3'd0;
   localparam logic [2:0] TX_WAIT  = 3'd1;
   localparam logic [2:0] TX_START = 3'd2;
   localparam logic [2:0] TX_DATA  = 3'd3;
   localparam logic [2:0] TX_PAR   = 3'd4;
   localparam logic [2:0] TX_STOP  = 3'd5;

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_PAR   = 3'd3;
   localparam logic [2:0] RX_STOP  = 3'd4;

   // ---------------- oversample tick ----------------
   logic [CW-1:0] div_cnt_reg;
   logic          tick;

   always_ff @(posedge CLK or posedge rst_p) begin
      if (rst_p)
         div_cnt_reg <= '0;
      else if (div_cnt_reg == DIV_LAST)
         div_cnt_reg <= '0;
      else
         div_cnt_reg <= div_cnt_reg + DIV_ONE;
   end

   assign tick     = (div_cnt_reg == DIV_LAST);
   assign tick_16x = tick;

   // ---------------- receiver ----------------
   logic [1:0]           sync_reg;
   logic                 rx_s;
   logic [2:0]           rx_state_reg, rx_state_next;
   logic [3:0]           rx_tcnt_reg, rx_tcnt_next;
   logic [3:0]           rx_bit_reg, rx_bit_next;
   logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
   logic                 rx_par_reg, rx_par_next;
   logic                 rx_ferr_acc_reg, rx_ferr_acc_next;
   logic                 rx_done;
   logic                 rx_sample;
   logic                 rx_ferr_now, rx_perr_now, rx_good;

   assign rx_s      = sync_reg[1];
   assign rx_sample = tick && (rx_tcnt_reg == 4'd15);

   always_comb begin
      rx_state_next    = rx_state_reg;
      rx_tcnt_next     = rx_tcnt_reg;
      rx_bit_next      = rx_bit_reg;
      rx_shift_next    = rx_shift_reg;
      rx_par_next      = rx_par_reg;
      rx_ferr_acc_next = rx_ferr_acc_reg;
      rx_done          = 1'b0;
      if (tick && rx_state_reg != RX_IDLE)
         rx_tcnt_next = rx_tcnt_reg + 4'd1;
      case (rx_state_reg)
         RX_IDLE: begin
            if (tick && !rx_s) begin
               rx_state_next = RX_START;
               rx_tcnt_next  = 4'd0;
            end
         end
         RX_START: begin
            // Half a bit after the falling edge: confirm the start bit, otherwise it was a glitch
            if (tick && rx_tcnt_reg == 4'd7) begin
               rx_tcnt_next = 4'd0;
               if (!rx_s) begin
                  rx_state_next    = RX_DATA;
                  rx_bit_next      = 4'd0;
                  rx_ferr_acc_next = 1'b0;
               end else begin
                  rx_state_next = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (rx_sample) begin
               rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
               if (rx_bit_reg == DATA_LAST) begin
                  rx_state_next = PAR_EN ? RX_PAR : RX_STOP;
                  rx_bit_next   = 4'd0;
               end else begin
                  rx_bit_next = rx_bit_reg + 4'd1;
               end
            end
         end
         RX_PAR: begin
            if (rx_sample) begin
               rx_par_next   = rx_s;
               rx_state_next = RX_STOP;
               rx_bit_next   = 4'd0;
            end
         end
         RX_STOP: begin
            if (rx_sample) begin
               rx_ferr_acc_next = rx_ferr_acc_reg | ~rx_s;
               if (rx_bit_reg == STOP_LAST) begin
                  rx_done       = 1'b1;
                  rx_state_next = RX_IDLE;
               end else begin
                  rx_bit_next = rx_bit_reg + 4'd1;
               end
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   assign rx_ferr_now = rx_ferr_acc_reg | ~rx_s;
   assign rx_perr_now = PAR_EN && (rx_par_reg != ((^rx_shift_reg) ^ PAR_ODD));
   assign rx_good     = !rx_ferr_now && !rx_perr_now;

   always_ff @(posedge CLK or posedge rst_p) begin
      if (rst_p) begin
         sync_reg        <= 2'b11;
         rx_state_reg    <= RX_IDLE;
         rx_tcnt_reg     <= 4'd0;
         rx_bit_reg      <= 4'd0;
         rx_shift_reg    <= '0;
         rx_par_reg      <= 1'b0;
         rx_ferr_acc_reg <= 1'b0;
      end else begin
         sync_reg        <= {sync_reg[0], rxd};
         rx_state_reg    <= rx_state_next;
         rx_tcnt_reg     <= rx_tcnt_next;
         rx_bit_reg      <= rx_bit_next;
         rx_shift_reg    <= rx_shift_next;
         rx_par_reg      <= rx_par_next;
         rx_ferr_acc_reg <= rx_ferr_acc_next;
      end
   end

   // Holding register: a completion always wins; overrun only if the old word was never consumed
   always_ff @(posedge CLK or posedge rst_p) begin
      if (rst_p) begin
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_perr    <= 1'b0;
         rx_ferr    <= 1'b0;
         rx_overrun <= 1'b0;
      end else if (rx_done) begin
         rx_valid   <= 1'b1;
         rx_data    <= rx_shift_reg;
         rx_perr    <= rx_perr_now;
         rx_ferr    <= rx_ferr_now;
         rx_overrun <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end
   end

   // ---------------- transmitter ----------------
   logic [2:0]           tx_state_reg, tx_state_next;
   logic [3:0]           tx_tcnt_reg, tx_tcnt_next;
   logic [3:0]           tx_bit_reg, tx_bit_next;
   logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
   logic                 tx_par_reg, tx_par_next;
   logic                 txd_reg, txd_next;
   logic                 run_reg;
   logic                 tx_load;
   logic [DATA_BITS-1:0] tx_load_data;
   logic                 tx_bit_end;

   assign tx_ready   = run_reg && (tx_state_reg == TX_IDLE) && !echo_en;
   assign tx_bit_end = tick && (tx_tcnt_reg == 4'd15);
   assign txd        = txd_reg;

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_tcnt_next  = tx_tcnt_reg;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      tx_par_next   = tx_par_reg;
      tx_load       = 1'b0;
      tx_load_data  = tx_data;
      // echo_en only matters while idle, so a frame in flight always completes
      if (tx_state_reg == TX_IDLE) begin
         if (echo_en) begin
            if (rx_done && rx_good) begin
               tx_load      = 1'b1;
               tx_load_data = rx_shift_reg;
            end
         end else if (tx_valid && tx_ready) begin
            tx_load = 1'b1;
         end
      end
      if (tick && tx_state_reg != TX_IDLE && tx_state_reg != TX_WAIT)
         tx_tcnt_next = tx_tcnt_reg + 4'd1;
      case (tx_state_reg)
         TX_IDLE: begin
            if (tx_load) begin
               tx_state_next = TX_WAIT;
               tx_shift_next = tx_load_data;
               tx_par_next   = (^tx_load_data) ^ PAR_ODD;
            end
         end
         TX_WAIT: begin
            if (tick) begin
               tx_state_next = TX_START;
               tx_tcnt_next  = 4'd0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_next = TX_DATA;
               tx_bit_next   = 4'd0;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_next = tx_shift_reg >> 1;
               if (tx_bit_reg == DATA_LAST) begin
                  tx_state_next = PAR_EN ? TX_PAR : TX_STOP;
                  tx_bit_next   = 4'd0;
               end else begin
                  tx_bit_next = tx_bit_reg + 4'd1;
               end
            end
         end
         TX_PAR: begin
            if (tx_bit_end) begin
               tx_state_next = TX_STOP;
               tx_bit_next   = 4'd0;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_bit_reg == STOP_LAST)
                  tx_state_next = TX_IDLE;
               else
                  tx_bit_next = tx_bit_reg + 4'd1;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase
      // Line level is registered from the next state so txd is glitch-free and aligned with the state
      case (tx_state_next)
         TX_START: txd_next = 1'b0;
         TX_DATA:  txd_next = tx_shift_next[0];
         TX_PAR:   txd_next = tx_par_next;
         default:  txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge rst_p) begin
      if (rst_p) begin
         tx_state_reg <= TX_IDLE;
         tx_tcnt_reg  <= 4'd0;
         tx_bit_reg   <= 4'd0;
         tx_shift_reg <= '0;
         tx_par_reg   <= 1'b0;
         txd_reg      <= 1'b1;
         run_reg      <= 1'b0;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_tcnt_reg  <= tx_tcnt_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         tx_par_reg   <= tx_par_next;
         txd_reg      <= txd_next;
         run_reg      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr at DIV=4: an 8N1 instance for TX/RX/echo/reset behaviour and an 8E1 instance for parity.
`timescale 1ns/1ps
module tb_uart_xcvr;
   localparam int DIV = 4;
   localparam int BIT = 16 * DIV;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst_p;
   logic       rxd_n, txd_n, tx_valid_n, tx_ready_n, rx_valid_n, rx_ready_n;
   logic       rx_perr_n, rx_ferr_n, rx_ovr_n, echo_en_n, tick_n;
   logic [7:0] tx_data_n, rx_data_n;
   logic       rxd_e, txd_e, tx_valid_e, tx_ready_e, rx_valid_e, rx_ready_e;
   logic       rx_perr_e, rx_ferr_e, rx_ovr_e, echo_en_e, tick_e;
   logic [7:0] tx_data_e, rx_data_e;

   uart_xcvr #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
      .CLK(CLK), .rst_p(rst_p), .rxd(rxd_n), .txd(txd_n),
      .tx_valid(tx_valid_n), .tx_data(tx_data_n), .tx_ready(tx_ready_n),
      .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_data(rx_data_n),
      .rx_perr(rx_perr_n), .rx_ferr(rx_ferr_n), .rx_overrun(rx_ovr_n),
      .echo_en(echo_en_n), .tick_16x(tick_n));

   uart_xcvr #(.DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
      .CLK(CLK), .rst_p(rst_p), .rxd(rxd_e), .txd(txd_e),
      .tx_valid(tx_valid_e), .tx_data(tx_data_e), .tx_ready(tx_ready_e),
      .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_data(rx_data_e),
      .rx_perr(rx_perr_e), .rx_ferr(rx_ferr_e), .rx_overrun(rx_ovr_e),
      .echo_en(echo_en_e), .tick_16x(tick_e));

   int checks = 0;
   int errors = 0;

   typedef struct { logic [7:0] data; logic [9:0] line; } tx_vec_t;
   typedef struct { logic [7:0] data; logic stop; logic exp_ferr; } rx_vec_t;
   tx_vec_t tx_tab[4];
   rx_vec_t rx_tab[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Line bits of one frame, bit 0 = start bit; pmode 0 none, 1 odd, 2 even
   function automatic logic [11:0] line_bits(input logic [7:0] d, input int pmode,
                                              input logic par_flip, input logic stop_val);
      logic [11:0] b;
      int ones;
      int n;
      b = '1;
      b[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         b[1 + i] = d[i];
         ones += int'(d[i]);
      end
      n = 9;
      if (pmode != 0) begin
         b[9] = ((ones % 2) == 1) ^ (pmode == 1) ^ par_flip;
         n = 10;
      end
      b[n] = stop_val;
      return b;
   endfunction

   task automatic send_tx(input logic [7:0] d);
      int t;
      t = 0;
      while (tx_ready_n !== 1'b1 && t < 2000) begin
         @(negedge CLK);
         t++;
      end
      check("tx_ready_before_send", tx_ready_n, 1);
      tx_data_n  = d;
      tx_valid_n = 1'b1;
      @(negedge CLK);
      tx_valid_n = 1'b0;
      tx_data_n  = ~d;
   endtask

   // Samples each bit at its centre; returns at the last negedge before the frame ends
   task automatic capture_tx(output logic [9:0] bits, output logic ready_low);
      int t;
      t = 0;
      bits = '1;
      ready_low = 1'b1;
      while (txd_n !== 1'b0 && t < 3000) begin
         @(negedge CLK);
         t++;
      end
      check("tx_start_seen", txd_n, 0);
      for (int i = 0; i < 10; i++) begin
         repeat ((i == 0) ? BIT / 2 : BIT) @(negedge CLK);
         bits[i] = txd_n;
         if (tx_ready_n !== 1'b0) ready_low = 1'b0;
      end
      repeat (BIT / 2 - 1) @(negedge CLK);
      if (tx_ready_n !== 1'b0) ready_low = 1'b0;
   endtask

   task automatic set_line(input bit sel_e, input logic v);
      if (sel_e) rxd_e = v;
      else       rxd_n = v;
   endtask

   task automatic drive_rx(input bit sel_e, input logic [11:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         set_line(sel_e, b[i]);
         repeat (BIT) @(negedge CLK);
      end
      set_line(sel_e, 1'b1);
   endtask

   task automatic check_rx(input bit sel_e, input string name, input logic [7:0] d,
                           input logic perr, input logic ferr, input logic ovr);
      if (sel_e)
         check(name, {rx_valid_e, rx_perr_e, rx_ferr_e, rx_ovr_e, rx_data_e}, {1'b1, perr, ferr, ovr, d});
      else
         check(name, {rx_valid_n, rx_perr_n, rx_ferr_n, rx_ovr_n, rx_data_n}, {1'b1, perr, ferr, ovr, d});
   endtask

   task automatic consume(input bit sel_e);
      if (sel_e) rx_ready_e = 1'b1; else rx_ready_n = 1'b1;
      @(negedge CLK);
      rx_ready_e = 1'b0;
      rx_ready_n = 1'b0;
      @(negedge CLK);
      if (sel_e) check("rx_consumed_e", {rx_valid_e, rx_ovr_e}, 0);
      else       check("rx_consumed_n", {rx_valid_n, rx_ovr_n}, 0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   logic [9:0]  bits;
   logic        rdy_low;
   logic [7:0]  d;
   logic        flip, stop;
   int          n;

   initial begin
      tx_tab[0] = '{8'h55, 10'b1010101010};
      tx_tab[1] = '{8'h0F, 10'b1000011110};
      tx_tab[2] = '{8'h00, 10'b1000000000};
      tx_tab[3] = '{8'hFF, 10'b1111111110};
      rx_tab[0] = '{8'hA5, 1'b1, 1'b0};
      rx_tab[1] = '{8'h01, 1'b1, 1'b0};
      rx_tab[2] = '{8'hFE, 1'b0, 1'b1};

      rst_p = 1'b1;
      rxd_n = 1'b1; rxd_e = 1'b1;
      tx_valid_n = 1'b0; tx_data_n = 8'h00; rx_ready_n = 1'b0; echo_en_n = 1'b0;
      tx_valid_e = 1'b0; tx_data_e = 8'h00; rx_ready_e = 1'b0; echo_en_e = 1'b0;
      repeat (3) @(negedge CLK);

      check("reset_txd", {txd_n, txd_e}, 2'b11);
      check("reset_tx_ready", {tx_ready_n, tx_ready_e}, 0);
      check("reset_rx_valid", {rx_valid_n, rx_valid_e}, 0);
      check("reset_rx_data", {rx_data_n, rx_data_e}, 0);
      check("reset_flags", {rx_perr_n, rx_ferr_n, rx_ovr_n, rx_perr_e, rx_ferr_e, rx_ovr_e}, 0);
      check("reset_tick", {tick_n, tick_e}, 0);

      rst_p = 1'b0;
      @(negedge CLK);
      check("tx_ready_after_release", tx_ready_n, 1);
      n = 0;
      while (tick_n !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
      @(negedge CLK);
      n = 1;
      while (tick_n !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
      check("tick_period", n, DIV);

      // table-driven TX frames
      for (int i = 0; i < 4; i++) begin
         send_tx(tx_tab[i].data);
         capture_tx(bits, rdy_low);
         check($sformatf("tx_tab[%0d]_line", i), bits, tx_tab[i].line);
         check($sformatf("tx_tab[%0d]_ready_low", i), rdy_low, 1);
         @(negedge CLK);
         check($sformatf("tx_tab[%0d]_ready_after", i), tx_ready_n, 1);
      end

      // bit length of 0x55: start and first data bit each last exactly 16*DIV cycles
      send_tx(8'h55);
      n = 0;
      while (txd_n !== 1'b0 && n < 200) begin @(negedge CLK); n++; end
      n = 0;
      while (txd_n === 1'b0 && n < 200) begin @(negedge CLK); n++; end
      check("tx_start_bit_len", n, BIT);
      n = 0;
      while (txd_n === 1'b1 && n < 200) begin @(negedge CLK); n++; end
      check("tx_data0_bit_len", n, BIT);

      // randomized back-to-back TX frames against the line model
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         send_tx(d);
         capture_tx(bits, rdy_low);
         check($sformatf("tx_rand[%0d]_%02h", i, d), bits, line_bits(d, 0, 1'b0, 1'b1) & 12'h3FF);
         @(negedge CLK);
      end

      // table-driven RX frames
      for (int i = 0; i < 3; i++) begin
         drive_rx(1'b0, line_bits(rx_tab[i].data, 0, 1'b0, rx_tab[i].stop), 10);
         repeat (100) @(negedge CLK);
         check_rx(1'b0, $sformatf("rx_tab[%0d]", i), rx_tab[i].data, 1'b0, rx_tab[i].exp_ferr, 1'b0);
         consume(1'b0);
      end

      // randomized RX frames, occasionally with a broken stop bit
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         drive_rx(1'b0, line_bits(d, 0, 1'b0, stop), 10);
         repeat (100) @(negedge CLK);
         check_rx(1'b0, $sformatf("rx_rand[%0d]", i), d, 1'b0, !stop, 1'b0);
         consume(1'b0);
      end

      // false start: 5 ticks low, then a real frame
      rxd_n = 1'b0;
      repeat (5 * DIV) @(negedge CLK);
      rxd_n = 1'b1;
      repeat (700) @(negedge CLK);
      check("rx_false_start_no_valid", rx_valid_n, 0);
      drive_rx(1'b0, line_bits(8'h3C, 0, 1'b0, 1'b1), 10);
      repeat (20) @(negedge CLK);
      check_rx(1'b0, "rx_after_false_start", 8'h3C, 1'b0, 1'b0, 1'b0);
      consume(1'b0);

      // overrun
      drive_rx(1'b0, line_bits(8'h11, 0, 1'b0, 1'b1), 10);
      repeat (100) @(negedge CLK);
      drive_rx(1'b0, line_bits(8'h22, 0, 1'b0, 1'b1), 10);
      repeat (20) @(negedge CLK);
      check_rx(1'b0, "rx_overrun", 8'h22, 1'b0, 1'b0, 1'b1);
      consume(1'b0);

      // parity on the 8E1 instance
      drive_rx(1'b1, line_bits(8'hA3, 2, 1'b0, 1'b1), 11);
      repeat (20) @(negedge CLK);
      check("rx_e_par_bit_a3", line_bits(8'hA3, 2, 1'b0, 1'b1) & 12'h200, 0);
      check_rx(1'b1, "rx_e_a3_good", 8'hA3, 1'b0, 1'b0, 1'b0);
      consume(1'b1);
      drive_rx(1'b1, line_bits(8'hA3, 2, 1'b1, 1'b1), 11);
      repeat (20) @(negedge CLK);
      check_rx(1'b1, "rx_e_a3_perr", 8'hA3, 1'b1, 1'b0, 1'b0);
      consume(1'b1);
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         flip = 1'($urandom_range(0, 1));
         drive_rx(1'b1, line_bits(d, 2, flip, 1'b1), 11);
         repeat (20) @(negedge CLK);
         check_rx(1'b1, $sformatf("rx_e_rand[%0d]", i), d, flip, 1'b0, 1'b0);
         consume(1'b1);
      end

      // echo of a good frame, then no echo of a framing-error frame
      echo_en_n = 1'b1;
      @(negedge CLK);
      check("echo_tx_ready_low", tx_ready_n, 0);
      fork
         drive_rx(1'b0, line_bits(8'h7E, 0, 1'b0, 1'b1), 10);
         capture_tx(bits, rdy_low);
      join
      check("echo_line_7e", bits, line_bits(8'h7E, 0, 1'b0, 1'b1) & 12'h3FF);
      check("echo_ready_low", rdy_low, 1);
      check_rx(1'b0, "echo_rx_7e", 8'h7E, 1'b0, 1'b0, 1'b0);
      consume(1'b0);
      n = 0;
      fork
         drive_rx(1'b0, line_bits(8'h81, 0, 1'b0, 1'b0), 10);
         begin
            for (int i = 0; i < 1400; i++) begin
               @(negedge CLK);
               if (txd_n !== 1'b1) n++;
            end
         end
      join
      check("echo_ferr_txd_idle", n, 0);
      check_rx(1'b0, "echo_rx_ferr", 8'h81, 1'b0, 1'b1, 1'b0);
      consume(1'b0);
      echo_en_n = 1'b0;

      // reset in the middle of data bit 4
      send_tx(8'h00);
      n = 0;
      while (txd_n !== 1'b0 && n < 200) begin @(negedge CLK); n++; end
      repeat (BIT / 2 + 5 * BIT) @(negedge CLK);
      check("mid_frame_txd_before_rst", txd_n, 0);
      #1 rst_p = 1'b1;
      #1 check("mid_frame_txd_in_rst", {txd_n, tx_ready_n}, 2'b10);
      repeat (3) @(negedge CLK);
      rst_p = 1'b0;
      @(negedge CLK);
      check("tx_ready_after_rst2", tx_ready_n, 1);
      send_tx(8'h0F);
      capture_tx(bits, rdy_low);
      check("tx_after_rst_0f", bits, 10'b1000011110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
